unified_buffer_streamer: RTL

//  Next-generation unified buffer: lane-masked host port plus an autonomous stream-read engine.
//  The engine walks a contiguous row range and feeds the systolic array over a valid/ready interface.
//  The host port and the stream engine have independent read ports, so the host can reload weights while a stream runs.

---
 rtl/ub_pkg.sv | 8 +
 rtl/ub_skew_stage.sv | 40 ++++
 rtl/unified_buffer_streamer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ub_pkg.sv
// Shared FSM state type and default lane geometry for the unified buffer streamer.
package ub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} ub_state_t;

    localparam int UB_LANES      = 4;
    localparam int UB_LANE_W     = 8;
    localparam int UB_FIFO_DEPTH = 2;
endpackage

// File: rtl/ub_skew_stage.sv
// Handshake-gated per-lane delay line: lane k of the output is lane k of the input from k beats earlier.
module ub_skew_stage
    import ub_pkg::*;
#(
    parameter int LANES  = UB_LANES,
    parameter int LANE_W = UB_LANE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data
);
    // Every input beat produces exactly one output beat, so the stage is a pass-through for flow control.
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

    assign out_data[0 +: LANE_W] = in_data[0 +: LANE_W];

    for (genvar k = 1; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] line_p0 [k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < k; j++) line_p0[j] <= '0;
            end else if (clr) begin
                for (int j = 0; j < k; j++) line_p0[j] <= '0;
            end else if (in_valid && out_ready) begin
                line_p0[0] <= in_data[k*LANE_W +: LANE_W];
                for (int j = 1; j < k; j++) line_p0[j] <= line_p0[j-1];
            end
        end

        assign out_data[k*LANE_W +: LANE_W] = line_p0[k-1];
    end
endmodule

// File: rtl/unified_buffer_streamer.sv
// Unified buffer: lane-masked host port plus a stream-read engine feeding the systolic array.
// Define UB_SKEW_EN to add the wavefront skew stage (stream gains LANES-1 zero-padded beats).
module unified_buffer_streamer
    import ub_pkg::*;
#(
    parameter int  LANES  = UB_LANES,
    parameter int  LANE_W = UB_LANE_W,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int DATA_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_we,
    input  logic [LANES-1:0]  h_lane_en,
    input  logic              h_re,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    input  logic              s_start,
    input  logic [ADDR_W-1:0] s_base,
    input  logic [ADDR_W:0]   s_len,
    output logic              s_busy,
    output logic              s_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);
    localparam int CNT_W = $clog2(DEPTH + LANES) + 1;
`ifdef UB_SKEW_EN
    localparam int PAD = LANES - 1;
`else
    localparam int PAD = 0;
`endif
    localparam logic [ADDR_W:0]  LEN_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];

    ub_state_t         state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  total_m1;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] fifo_mem [UB_FIFO_DEPTH];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              accept, rd_en, last_rd, beat, last_beat;
    logic              src_from_fifo, src_valid, pop;
    logic [DATA_W-1:0] src_data;

    assign accept   = s_start && (state == IDLE || state == FIN);
    assign last_rd  = (rd_cnt == len_q - LEN_ONE);
    assign rd_addr  = base_q + rd_cnt[ADDR_W-1:0];
    assign total_m1 = CNT_W'(len_q) + CNT_W'(PAD) - CNT_ONE;
    assign beat     = m_valid && m_ready;
    assign last_beat = beat && (out_cnt == total_m1);

    // Real rows come from the FIFO; once they are all delivered the padding beats are zeros.
    assign src_from_fifo = (out_cnt < CNT_W'(len_q));
    assign src_valid     = src_from_fifo ? (fifo_cnt != 2'd0) : (state == DRAIN);
    assign src_data      = src_from_fifo ? fifo_mem[rd_ptr] : '0;

`ifdef UB_SKEW_EN
    logic src_ready;

    ub_skew_stage #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_skew (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .in_valid  (src_valid),
        .in_ready  (src_ready),
        .in_data   (src_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data)
    );
    assign pop = src_from_fifo && src_valid && src_ready;
`else
    assign m_valid = src_valid;
    assign m_data  = src_data;
    assign pop     = src_from_fifo && src_valid && m_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (s_start) state_nx = (s_len == '0) ? FIN : RUN;
            end
            RUN:     if (rd_en && last_rd) state_nx = DRAIN;
            DRAIN:   if (last_beat) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_busy = (state == RUN) || (state == DRAIN);
        s_done = (state == FIN);
        rd_en  = (state == RUN) && (fifo_cnt < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
        end else if (accept) begin
            base_q  <= s_base;
            len_q   <= s_len;
            rd_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (rd_en) rd_cnt  <= rd_cnt + LEN_ONE;
            if (beat)  out_cnt <= out_cnt + CNT_ONE;
        end
    end

    // Stream read port: the RAM read lands directly in the output FIFO (read latency 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UB_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (rd_en) begin
                fifo_mem[wr_ptr] <= mem[rd_addr];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({rd_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Host read port: registered, holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rdata  <= '0;
            h_rvalid <= 1'b0;
        end else begin
            h_rvalid <= h_re;
            if (h_re) h_rdata <= mem[h_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (h_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (h_lane_en[l]) mem[h_addr][l*LANE_W +: LANE_W] <= h_wdata[l*LANE_W +: LANE_W];
            end
        end
    end
endmodule
